// File: rtl/seg7_rx_checker_pkg.sv
// ---------------------------------------------------------------------------
// seg7_rx_checker_pkg
//   Shared definitions for the 7-segment link: the segment code for each hex
//   digit (bit0 = a .. bit6 = g, active-high), the blank code, and the
//   receive-checker state type. The transmit-side encoder uses the same codes,
//   so both ends of the loopback agree on one table.
// ---------------------------------------------------------------------------
package seg7_rx_checker_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // S_EMPTY: no reference digit held; S_LOCKED: last accepted digit is the
  // reference for the next +1 check.
  typedef enum logic {
    S_EMPTY  = 1'b0,
    S_LOCKED = 1'b1
  } rx_state_e;

endpackage

// File: rtl/seg7_rx_checker_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   Combinational decoder from a 7-bit segment pattern back to a hex digit.
//   Ports:
//     pattern   in  7  segment pattern (bit0 = a .. bit6 = g)
//     is_valid  out 1  pattern is one of the 16 digit codes
//     is_blank  out 1  pattern is all segments off
//     digit     out 4  decoded digit (0 when not valid)
// ---------------------------------------------------------------------------
module seg7_decode
  import seg7_rx_checker_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       is_valid,
  output logic       is_blank,
  output logic [3:0] digit
);

  always_comb begin
    is_valid = 1'b1;
    is_blank = 1'b0;
    digit    = 4'h0;
    case (pattern)
      SEG_0:     digit = 4'h0;
      SEG_1:     digit = 4'h1;
      SEG_2:     digit = 4'h2;
      SEG_3:     digit = 4'h3;
      SEG_4:     digit = 4'h4;
      SEG_5:     digit = 4'h5;
      SEG_6:     digit = 4'h6;
      SEG_7:     digit = 4'h7;
      SEG_8:     digit = 4'h8;
      SEG_9:     digit = 4'h9;
      SEG_A:     digit = 4'hA;
      SEG_B:     digit = 4'hB;
      SEG_C:     digit = 4'hC;
      SEG_D:     digit = 4'hD;
      SEG_E:     digit = 4'hE;
      SEG_F:     digit = 4'hF;
      SEG_BLANK: begin
        is_valid = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_rx_checker.sv
// ---------------------------------------------------------------------------
// seg7_rx_checker
//   Receive side of the 7-segment loopback self-check. Synchronises the
//   segment bus, waits for a pattern to be stable, decodes it and checks that
//   successive accepted digits count up by one (mod 16).
//   Parameters:
//     STABLE_CYCLES  identical synchronised samples needed to accept (>= 1)
//     ERR_W          width of the saturating sequence-error counter
//   Ports:
//     clk          in   1      system clock
//     rst_n        in   1      synchronous active-low reset
//     seg_in       in   7      segment bus, asynchronous to clk
//     digit        out  4      last accepted digit
//     digit_valid  out  1      one-cycle pulse per accepted digit
//     pattern_err  out  1      one-cycle pulse per accepted undecodable pattern
//     locked       out  1      a reference digit is held
//     seq_err_cnt  out  ERR_W  saturating count of sequence violations
// ---------------------------------------------------------------------------
module seg7_rx_checker
  import seg7_rx_checker_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             locked,
  output logic [ERR_W-1:0] seq_err_cnt
);

  // The counter only ever needs to reach STABLE_CYCLES-1.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync1_reg, sync2_reg;
  logic [6:0]       prev_reg;
  logic [CNT_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic [6:0]       last_acc_reg, last_acc_next;
  rx_state_e        state_reg, state_next;
  logic [3:0]       digit_reg, digit_next;
  logic             digit_valid_reg, digit_valid_next;
  logic             pattern_err_reg, pattern_err_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

  logic             dec_valid, dec_blank;
  logic [3:0]       dec_digit;
  logic [3:0]       expect_digit;
  logic             accept;

  // Decode the pattern being counted (prev_reg), not the raw s2 sample, so
  // the accepted pattern is exactly the one that has been stable.
  seg7_decode u_decode (
    .pattern  (prev_reg),
    .is_valid (dec_valid),
    .is_blank (dec_blank),
    .digit    (dec_digit)
  );

  // Counter saturates at the threshold; together with the last-accepted
  // compare this makes acceptance fire once per change.
  always_comb begin
    stable_cnt_next = stable_cnt_reg;
    if (sync2_reg != prev_reg) begin
      stable_cnt_next = '0;
    end else if (stable_cnt_reg != CNT_LAST) begin
      stable_cnt_next = stable_cnt_reg + CNT_W'(1);
    end
  end

  assign accept       = (stable_cnt_reg == CNT_LAST) && (prev_reg != last_acc_reg);
  assign expect_digit = digit_reg + 4'd1;

  always_comb begin
    state_next       = state_reg;
    last_acc_next    = last_acc_reg;
    digit_next       = digit_reg;
    digit_valid_next = 1'b0;
    pattern_err_next = 1'b0;
    err_cnt_next     = err_cnt_reg;
    if (accept) begin
      last_acc_next = prev_reg;
      if (dec_valid) begin
        digit_next       = dec_digit;
        digit_valid_next = 1'b1;
        state_next       = S_LOCKED;
        if ((state_reg == S_LOCKED) && (dec_digit != expect_digit) &&
            (err_cnt_reg != {ERR_W{1'b1}})) begin
          err_cnt_next = err_cnt_reg + ERR_W'(1);
        end
      end else if (dec_blank) begin
        state_next = S_EMPTY;
      end else begin
        pattern_err_next = 1'b1;
        state_next       = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg       <= 7'h00;
      sync2_reg       <= 7'h00;
      prev_reg        <= 7'h00;
      stable_cnt_reg  <= '0;
      last_acc_reg    <= 7'h00;
      state_reg       <= S_EMPTY;
      digit_reg       <= 4'h0;
      digit_valid_reg <= 1'b0;
      pattern_err_reg <= 1'b0;
      err_cnt_reg     <= '0;
    end else begin
      sync1_reg       <= seg_in;
      sync2_reg       <= sync1_reg;
      prev_reg        <= sync2_reg;
      stable_cnt_reg  <= stable_cnt_next;
      last_acc_reg    <= last_acc_next;
      state_reg       <= state_next;
      digit_reg       <= digit_next;
      digit_valid_reg <= digit_valid_next;
      pattern_err_reg <= pattern_err_next;
      err_cnt_reg     <= err_cnt_next;
    end
  end

  assign digit       = digit_reg;
  assign digit_valid = digit_valid_reg;
  assign pattern_err = pattern_err_reg;
  assign locked      = (state_reg == S_LOCKED);
  assign seq_err_cnt = err_cnt_reg;

endmodule
